axil_reg_responder: RTL and testbench

AXI4-Lite slave register bank: the responder side of the PS general-purpose port's single-beat `write_data`/`read_data` register accesses. It sits on the PL side of the AXI interconnect and holds control and configuration registers for a stream engine (start pulse, source address, length, done/busy status, interrupt). It accepts one write and one read outstanding. Every access gets an OKAY or SLVERR response.

---
 rtl/axil_reg_responder_if.sv | 28 ++
 rtl/axil_reg_responder.sv | 191 +++++++++++++++++++
 tb/tb_axil_reg_responder.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_responder_if.sv
// AXI4-Lite bus bundle for the stream-engine register bank.
// The master modport is the PS side; the slave modport is the bank.
interface axil_reg_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid, awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid, wready;
  logic [1:0]              bresp;
  logic                    bvalid, bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid, arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid, rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_responder.sv
// AXI4-Lite register bank for the stream engine (CTRL/STATUS/SRC_ADDR/LENGTH/SCRATCH).
// Define AXIL_REG_IRQ_EN to build the IRQ_EN bit and the irq_o logic.
module axil_reg_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ps_clk,
  input  logic                  ps_aresetn,
  axil_reg_responder_if.slave   s_axil,
  input  logic                  busy_i,
  input  logic                  done_i,
  output logic                  start_o,
  output logic [DATA_WIDTH-1:0] src_addr_o,
  output logic [DATA_WIDTH-1:0] length_o,
  output logic                  irq_o
);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic                  init_q;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic                  ar_held_q, ar_held_d, busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
  logic [DATA_WIDTH-1:0] src_q, src_d, len_q, len_d, scr_q, scr_d;
  logic                  done_q, done_d, start_q, start_d;
  logic                  irq_en;

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                  input logic [DATA_WIDTH-1:0] nw,
                                                  input logic [SW-1:0]         strb);
    merge = old;
    for (int i = 0; i < SW; i++)
      if (strb[i]) merge[8*i +: 8] = nw[8*i +: 8];
  endfunction

  // Readies stay low until the first edge after reset release.
  assign s_axil.awready = init_q && !aw_held_q && !bvalid_q;
  assign s_axil.wready  = init_q && !w_held_q && !bvalid_q;
  assign s_axil.arready = init_q && !rvalid_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rresp   = rresp_q;
  assign s_axil.rdata   = rdata_q;
  assign start_o        = start_q;
  assign src_addr_o     = src_q;
  assign length_o       = len_q;

  logic       aw_hs, w_hs, ar_hs, wr_commit, wr_ok, wr_en, ar_take, rd_ok;
  logic [2:0] wr_idx, rd_idx;
  assign aw_hs     = s_axil.awvalid && s_axil.awready;
  assign w_hs      = s_axil.wvalid && s_axil.wready;
  assign ar_hs     = s_axil.arvalid && s_axil.arready;
  assign wr_commit = aw_held_q && w_held_q && !bvalid_q;
  assign wr_ok     = (awaddr_q >> 5) == '0;
  assign wr_en     = wr_commit && wr_ok;
  assign wr_idx    = awaddr_q[4:2];
  // A held AR turns into a response once the R slot is empty or draining.
  assign ar_take   = ar_held_q && (!rvalid_q || s_axil.rready);
  assign rd_ok     = (araddr_q >> 5) == '0;
  assign rd_idx    = araddr_q[4:2];

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, awaddr_q[1:0], araddr_q[1:0]};

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      3'd0:    rd_mux = {{(DATA_WIDTH-2){1'b0}}, irq_en, 1'b0};
      3'd1:    rd_mux = {{(DATA_WIDTH-2){1'b0}}, done_q, busy_q};
      3'd2:    rd_mux = src_q;
      3'd3:    rd_mux = len_q;
      3'd4:    rd_mux = scr_q;
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = aw_hs ? s_axil.awaddr : awaddr_q;
    wdata_d   = w_hs ? s_axil.wdata : wdata_q;
    wstrb_d   = w_hs ? s_axil.wstrb : wstrb_q;
    if (aw_hs) aw_held_d = 1'b1;
    if (w_hs)  w_held_d  = 1'b1;
    if (wr_commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (wr_commit) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_ok ? OKAY : SLVERR;
    end else if (bvalid_q && s_axil.bready) begin
      bvalid_d = 1'b0;
    end
    src_d   = (wr_en && wr_idx == 3'd2) ? merge(src_q, wdata_q, wstrb_q) : src_q;
    len_d   = (wr_en && wr_idx == 3'd3) ? merge(len_q, wdata_q, wstrb_q) : len_q;
    scr_d   = (wr_en && wr_idx == 3'd4) ? merge(scr_q, wdata_q, wstrb_q) : scr_q;
    start_d = wr_en && wr_idx == 3'd0 && wstrb_q[0] && wdata_q[0];
    // A done_i pulse beats a simultaneous write-1-to-clear.
    done_d  = done_i || (done_q && !(wr_en && wr_idx == 3'd1 && wstrb_q[0] && wdata_q[1]));

    ar_held_d = ar_hs ? 1'b1 : (ar_take ? 1'b0 : ar_held_q);
    araddr_d  = ar_hs ? s_axil.araddr : araddr_q;
    busy_d    = ar_hs ? busy_i : busy_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (ar_take) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? rd_mux : '0;
      rresp_d  = rd_ok ? OKAY : SLVERR;
    end else if (rvalid_q && s_axil.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ps_clk or negedge ps_aresetn) begin
    if (!ps_aresetn) begin
      init_q    <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      ar_held_q <= 1'b0;
      araddr_q  <= '0;
      busy_q    <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      src_q     <= '0;
      len_q     <= '0;
      scr_q     <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      init_q    <= 1'b1;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      ar_held_q <= ar_held_d;
      araddr_q  <= araddr_d;
      busy_q    <= busy_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      src_q     <= src_d;
      len_q     <= len_d;
      scr_q     <= scr_d;
      start_q   <= start_d;
      done_q    <= done_d;
    end
  end

`ifdef AXIL_REG_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;
  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_en && wr_idx == 3'd0 && wstrb_q[0]) irq_en_d = wdata_q[1];
    irq_d = done_q && irq_en_q;
  end
  always_ff @(posedge ps_clk or negedge ps_aresetn) begin
    if (!ps_aresetn) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end
  assign irq_en = irq_en_q;
  assign irq_o  = irq_q;
`else
  assign irq_en = 1'b0;
  assign irq_o  = 1'b0;
`endif
endmodule

// File: tb/tb_axil_reg_responder.sv
// Directed bench for axil_reg_responder: one task per scenario, inline checks.
// Expectations for IRQ_EN/irq_o follow whether AXIL_REG_IRQ_EN is defined.
module tb_axil_reg_responder;
`ifdef AXIL_REG_IRQ_EN
  localparam bit HAS_IRQ = 1'b1;
`else
  localparam bit HAS_IRQ = 1'b0;
`endif

  logic        clk, rstn, busy_i, done_i, start_o, irq_o;
  logic [31:0] src_addr_o, length_o;
  int          tests, fails;

  axil_reg_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  axil_reg_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .ps_clk(clk), .ps_aresetn(rstn), .s_axil(bus),
    .busy_i(busy_i), .done_i(done_i), .start_o(start_o),
    .src_addr_o(src_addr_o), .length_o(length_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output bit ok);
    bit awd, wd;
    ok = 0; resp = 2'bxx;
    @(negedge clk);
    bus.awaddr = a; bus.awvalid = 1; bus.wdata = d; bus.wstrb = s; bus.wvalid = 1; bus.bready = 1;
    for (int n = 0; n < 40 && !ok; n++) begin
      awd = bus.awvalid && bus.awready;
      wd  = bus.wvalid && bus.wready;
      @(posedge clk); @(negedge clk);
      if (awd) bus.awvalid = 0;
      if (wd)  bus.wvalid = 0;
      if (bus.bvalid) begin ok = 1; resp = bus.bresp; end
    end
    bus.awvalid = 0; bus.wvalid = 0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output bit ok);
    bit ard;
    ok = 0; d = 'x; resp = 2'bxx;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1; bus.rready = 1;
    for (int n = 0; n < 40 && !ok; n++) begin
      ard = bus.arvalid && bus.arready;
      @(posedge clk); @(negedge clk);
      if (ard) bus.arvalid = 0;
      if (bus.rvalid) begin ok = 1; d = bus.rdata; resp = bus.rresp; end
    end
    bus.arvalid = 0;
  endtask

  task automatic test_reset();
    logic [11:0] v;
    repeat (2) @(negedge clk);
    v = {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.bresp, bus.rresp,
         start_o, irq_o, |bus.rdata};
    tests++;
    if (v !== 12'h0 || src_addr_o !== 32'h0 || length_o !== 32'h0) begin
      fails++; $display("FAIL reset_state: flags=%h src=%h len=%h required 0", v, src_addr_o, length_o);
    end
    rstn = 1;
    #1 tests++;
    if (bus.awready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %b required 0", bus.awready); end
    @(posedge clk); @(negedge clk);
    tests++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      fails++; $display("FAIL ready_after_edge: got %b required 111", {bus.awready, bus.wready, bus.arready});
    end
  endtask

  task automatic test_write_read();
    logic [1:0] r; logic [31:0] d; bit ok;
    do_write(8'h08, 32'h8000C000, 4'hF, r, ok);
    tests++;
    if (!ok || r !== 2'b00 || src_addr_o !== 32'h8000C000) begin
      fails++; $display("FAIL src_write: ok=%0d bresp=%b src=%h required 00/8000c000", ok, r, src_addr_o);
    end
    do_read(8'h08, d, r, ok);
    tests++;
    if (!ok || d !== 32'h8000C000 || r !== 2'b00) begin
      fails++; $display("FAIL src_read: ok=%0d rdata=%h rresp=%b required 8000c000/00", ok, d, r);
    end
    do_write(8'h10, 32'hA5A55A5A, 4'hF, r, ok);
    do_read(8'h13, d, r, ok);
    tests++;
    if (!ok || d !== 32'hA5A55A5A || r !== 2'b00) begin
      fails++; $display("FAIL scratch_read: rdata=%h rresp=%b required a5a55a5a/00", d, r);
    end
    do_read(8'h14, d, r, ok);
    tests++;
    if (!ok || d !== 32'h0 || r !== 2'b00) begin
      fails++; $display("FAIL reserved_read: rdata=%h rresp=%b required 0/00", d, r);
    end
  endtask

  task automatic test_start_w_first();
    logic [3:0] pat; logic [1:0] r; logic [31:0] d; bit ok;
    @(negedge clk);
    bus.wdata = 32'h3; bus.wstrb = 4'hF; bus.wvalid = 1; bus.bready = 1;
    @(posedge clk); @(negedge clk); bus.wvalid = 0;
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    bus.awaddr = 8'h00; bus.awvalid = 1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) bus.awvalid = 0;
      pat[i] = start_o;
      @(posedge clk);
    end
    tests++;
    if (pat !== 4'b0010) begin fails++; $display("FAIL start_pulse: pattern=%b required 0010", pat); end
    do_read(8'h00, d, r, ok);
    tests++;
    if (!ok || d !== {30'h0, HAS_IRQ, 1'b0}) begin
      fails++; $display("FAIL ctrl_read: rdata=%h required %h", d, {30'h0, HAS_IRQ, 1'b0});
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r; bit ok;
    do_write(8'h0C, 32'h11223344, 4'hF, r, ok);
    do_write(8'h0C, 32'hFFFFFFFF, 4'b0010, r, ok);
    tests++;
    if (!ok || length_o !== 32'h1122FF44) begin
      fails++; $display("FAIL length_strobe: len=%h required 1122ff44", length_o);
    end
  endtask

  task automatic test_done_irq();
    logic [1:0] r; logic [31:0] d; bit ok;
    do_write(8'h00, 32'h2, 4'hF, r, ok);
    @(negedge clk); done_i = 1;
    @(posedge clk); @(negedge clk); done_i = 0;
    @(posedge clk); @(negedge clk);
    tests++;
    if (irq_o !== HAS_IRQ) begin fails++; $display("FAIL irq_set: got %b required %b", irq_o, HAS_IRQ); end
    do_read(8'h04, d, r, ok);
    tests++;
    if (!ok || d !== 32'h2) begin fails++; $display("FAIL status_done: rdata=%h required 2", d); end
    do_write(8'h04, 32'h2, 4'hF, r, ok);
    @(posedge clk); @(negedge clk);
    tests++;
    if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b required 0", irq_o); end
    // done_i stays high through the clearing write's commit edge
    done_i = 1;
    do_write(8'h04, 32'h2, 4'hF, r, ok);
    done_i = 0;
    do_read(8'h04, d, r, ok);
    tests++;
    if (!ok || d !== 32'h2) begin fails++; $display("FAIL done_set_wins: rdata=%h required 2", d); end
    busy_i = 1;
    do_write(8'h04, 32'h2, 4'hF, r, ok);
    do_read(8'h04, d, r, ok);
    busy_i = 0;
    tests++;
    if (!ok || d !== 32'h1) begin fails++; $display("FAIL status_busy: rdata=%h required 1", d); end
  endtask

  task automatic test_slverr();
    logic [1:0] r; logic [31:0] d; bit ok; int held, starts;
    @(negedge clk);
    bus.awaddr = 8'h40; bus.awvalid = 1; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF;
    bus.wvalid = 1; bus.bready = 0;
    @(posedge clk); @(negedge clk); bus.awvalid = 0; bus.wvalid = 0;
    @(posedge clk);
    held = 0; starts = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.bvalid && !bus.awready && !bus.wready) held++;
      if (start_o) starts++;
      @(posedge clk);
    end
    @(negedge clk);
    tests++;
    if (held !== 5 || bus.bresp !== 2'b10 || starts !== 0) begin
      fails++; $display("FAIL slverr_hold: held=%0d bresp=%b starts=%0d required 5/10/0", held, bus.bresp, starts);
    end
    bus.bready = 1;
    @(posedge clk); @(negedge clk);
    tests++;
    if (bus.bvalid !== 1'b0) begin fails++; $display("FAIL bvalid_drop: got %b required 0", bus.bvalid); end
    do_read(8'h40, d, r, ok);
    tests++;
    if (!ok || d !== 32'h0 || r !== 2'b10) begin
      fails++; $display("FAIL slverr_read: rdata=%h rresp=%b required 0/10", d, r);
    end
    do_write(8'h48, 32'h12345678, 4'hF, r, ok);
    do_read(8'h48, d, r, ok);
    tests++;
    if (!ok || d !== 32'h0 || r !== 2'b10 || src_addr_o !== 32'h8000C000 || length_o !== 32'h1122FF44) begin
      fails++; $display("FAIL slverr_no_change: rdata=%h rresp=%b src=%h len=%h", d, r, src_addr_o, length_o);
    end
    do_read(8'h00, d, r, ok);
    tests++;
    if (!ok || d !== {30'h0, HAS_IRQ, 1'b0}) begin
      fails++; $display("FAIL ctrl_unchanged: rdata=%h required %h", d, {30'h0, HAS_IRQ, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; logic [31:0] d; bit ok;
    @(negedge clk); done_i = 1;
    @(posedge clk); @(negedge clk); done_i = 0;
    bus.araddr = 8'h08; bus.arvalid = 1; bus.rready = 0;
    @(posedge clk); @(negedge clk); bus.arvalid = 0;
    @(posedge clk); @(negedge clk);
    tests++;
    if (bus.rvalid !== 1'b1 || irq_o !== HAS_IRQ) begin
      fails++; $display("FAIL pre_reset: rvalid=%b irq=%b required 1/%b", bus.rvalid, irq_o, HAS_IRQ);
    end
    rstn = 0;
    #1 tests++;
    if (bus.rvalid !== 1'b0 || irq_o !== 1'b0 || src_addr_o !== 32'h0 || length_o !== 32'h0) begin
      fails++; $display("FAIL async_reset: rvalid=%b irq=%b src=%h len=%h required 0", bus.rvalid, irq_o, src_addr_o, length_o);
    end
    @(negedge clk); bus.rready = 1; rstn = 1;
    @(posedge clk); @(negedge clk);
    tests++;
    if (bus.rvalid !== 1'b0) begin fails++; $display("FAIL no_stale_resp: rvalid=%b required 0", bus.rvalid); end
    do_read(8'h04, d, r, ok);
    tests++;
    if (!ok || d !== 32'h0) begin fails++; $display("FAIL status_after_reset: rdata=%h required 0", d); end
    do_read(8'h10, d, r, ok);
    tests++;
    if (!ok || d !== 32'h0) begin fails++; $display("FAIL scratch_after_reset: rdata=%h required 0", d); end
  endtask

  initial begin
    clk = 0; rstn = 0; busy_i = 0; done_i = 0;
    tests = 0; fails = 0;
    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    test_reset();
    test_write_read();
    test_start_w_first();
    test_strobe();
    test_done_irq();
    test_slverr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
